// File: rtl/obj_dma_pkg.sv
// obj_dma_pkg: shared FSM encoding, table geometry and config bundle
// for the object-table DMA. No ports; imported by obj_dma and obj_dma_ctr.
package obj_dma_pkg;

  localparam int OBJ_TABLE_LEN = 128;
  localparam int CNT_W         = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_VB,
    ST_REQ,
    ST_RD,
    ST_LAT,
    ST_WR,
    ST_FIN
  } dma_st_t;

  typedef struct packed {
    logic [7:0] base;
    logic       obex;
  } dma_cfg_t;

endpackage

// File: rtl/obj_dma_ctr.sv
// obj_dma_ctr: byte counter for the object DMA; saturates at the last
// table entry. Ports: clk/reset, clr, en in; cnt, tc (last entry) out.
module obj_dma_ctr
  import obj_dma_pkg::*;
(
  input  logic             clkm_32MHZ,
  input  logic             nRESET,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  assign tc = (cnt == CNT_W'(OBJ_TABLE_LEN - 1));

  // Holding at tc keeps the source window from wrapping.
  always_ff @(posedge clkm_32MHZ or negedge nRESET) begin
    if (!nRESET)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en && !tc)
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/obj_dma.sv
// obj_dma: copies a 128-byte object table from source RAM to object RAM
// during vblank, 3 cycles per byte, pausing only between bytes.
// In: clk, nRESET, START, SRC_BASE, OBJEX, V_BLANK, BUS_GNT, SRC_DATA.
// Out: BUS_REQ, SRC_ADDR, SRC_RD_n, OBJ_ADDR, OBJ_DATA, OBJ_WE_n,
//      BUSY, DONE.
module obj_dma
  import obj_dma_pkg::*;
(
  input  logic        clkm_32MHZ,
  input  logic        nRESET,
  input  logic        START,
  input  logic [7:0]  SRC_BASE,
  input  logic        OBJEX,
  input  logic        V_BLANK,
  input  logic        BUS_GNT,
  input  logic [7:0]  SRC_DATA,
  output logic        BUS_REQ,
  output logic [15:0] SRC_ADDR,
  output logic        SRC_RD_n,
  output logic [7:0]  OBJ_ADDR,
  output logic [7:0]  OBJ_DATA,
  output logic        OBJ_WE_n,
  output logic        BUSY,
  output logic        DONE
);

  dma_st_t          st;
  dma_st_t          st_nx;
  dma_cfg_t         cfg;
  logic             pend;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic             tc;
  logic             ctr_clr;
  logic             ctr_en;
  logic             load;

  assign load    = (st == ST_IDLE && START) || (st == ST_FIN);
  assign ctr_clr = load;
  assign ctr_en  = (st == ST_WR);

  // Count the counter will hold on the next edge, so SRC_ADDR can be
  // registered ahead of RD.
  assign cnt_nx = (st == ST_WR) ? cnt + 1'b1 : cnt;

  obj_dma_ctr u_ctr (
    .clkm_32MHZ (clkm_32MHZ),
    .nRESET     (nRESET),
    .clr        (ctr_clr),
    .en         (ctr_en),
    .cnt        (cnt),
    .tc         (tc)
  );

  always_ff @(posedge clkm_32MHZ or negedge nRESET) begin
    if (!nRESET)
      st <= ST_IDLE;
    else
      st <= st_nx;
  end

  always_comb begin
    st_nx = st;
    unique case (st)
      ST_IDLE:
        if (START) st_nx = ST_WAIT_VB;
      ST_WAIT_VB:
        if (V_BLANK) st_nx = ST_REQ;
      ST_REQ:
        if (!V_BLANK)    st_nx = ST_WAIT_VB;
        else if (BUS_GNT) st_nx = ST_RD;
      ST_RD:
        st_nx = ST_LAT;
      ST_LAT:
        st_nx = ST_WR;
      ST_WR:
        if (tc)           st_nx = ST_FIN;
        else if (!V_BLANK) st_nx = ST_WAIT_VB;
        else if (!BUS_GNT) st_nx = ST_REQ;
        else              st_nx = ST_RD;
      ST_FIN:
        st_nx = (pend || START) ? ST_WAIT_VB : ST_IDLE;
      default:
        st_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    BUS_REQ  = 1'b0;
    SRC_RD_n = 1'b1;
    OBJ_WE_n = 1'b1;
    BUSY     = 1'b1;
    DONE     = 1'b0;
    unique case (st)
      ST_IDLE:    BUSY = 1'b0;
      ST_WAIT_VB: ;
      ST_REQ:     BUS_REQ = 1'b1;
      ST_RD: begin
        BUS_REQ  = 1'b1;
        SRC_RD_n = 1'b0;
      end
      ST_LAT:     BUS_REQ = 1'b1;
      ST_WR: begin
        BUS_REQ  = 1'b1;
        OBJ_WE_n = 1'b0;
      end
      ST_FIN:     DONE = 1'b1;
      default:    BUSY = 1'b0;
    endcase
  end

  always_ff @(posedge clkm_32MHZ or negedge nRESET) begin
    if (!nRESET) begin
      cfg      <= '0;
      pend     <= 1'b0;
      SRC_ADDR <= '0;
      OBJ_ADDR <= '0;
      OBJ_DATA <= '0;
    end else begin
      if (load)
        cfg <= '{base: SRC_BASE, obex: OBJEX};
      if (st == ST_FIN)
        pend <= 1'b0;
      else if (START && st != ST_IDLE)
        pend <= 1'b1;
      if (st_nx == ST_RD)
        SRC_ADDR <= {cfg.base, 1'b0, cnt_nx};
      if (st == ST_LAT) begin
        OBJ_DATA <= SRC_DATA;
        OBJ_ADDR <= {cfg.obex, cnt};
      end
    end
  end

endmodule

// File: tb/tb_obj_dma.sv
// tb_obj_dma: directed scenarios with random tables/bases, checked
// against an expected per-byte copy sequence built in the bench.
module tb_obj_dma;

  logic        clk = 1'b0;
  logic        nRESET = 1'b0;
  logic        START = 1'b0;
  logic [7:0]  SRC_BASE = 8'h00;
  logic        OBJEX = 1'b0;
  logic        V_BLANK = 1'b0;
  logic        BUS_GNT = 1'b0;
  logic [7:0]  SRC_DATA = 8'h00;
  logic        BUS_REQ;
  logic [15:0] SRC_ADDR;
  logic        SRC_RD_n;
  logic [7:0]  OBJ_ADDR;
  logic [7:0]  OBJ_DATA;
  logic        OBJ_WE_n;
  logic        BUSY;
  logic        DONE;

  always #15 clk = ~clk;

  obj_dma dut (
    .clkm_32MHZ (clk),
    .nRESET     (nRESET),
    .START      (START),
    .SRC_BASE   (SRC_BASE),
    .OBJEX      (OBJEX),
    .V_BLANK    (V_BLANK),
    .BUS_GNT    (BUS_GNT),
    .SRC_DATA   (SRC_DATA),
    .BUS_REQ    (BUS_REQ),
    .SRC_ADDR   (SRC_ADDR),
    .SRC_RD_n   (SRC_RD_n),
    .OBJ_ADDR   (OBJ_ADDR),
    .OBJ_DATA   (OBJ_DATA),
    .OBJ_WE_n   (OBJ_WE_n),
    .BUSY       (BUSY),
    .DONE       (DONE)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0]  key = 8'h00;
  int          cyc = 0;
  int          done_cnt = 0;
  int          done_cyc = -1;
  int          first_rd = -1;
  int          rd_dbl = 0;
  int          we_dbl = 0;
  int          done_dbl = 0;
  int          rd_novb = 0;
  logic [15:0] rd_log[$];
  logic [15:0] wr_log[$];
  logic        rd_q = 1'b0;
  logic [15:0] rd_a = 16'h0;
  logic        prev_rd = 1'b0;
  logic        prev_we = 1'b0;
  logic        prev_done = 1'b0;

  function automatic logic [7:0] mem(input logic [15:0] a);
    logic [7:0] h;
    h = a[15:8] * 8'd37;
    return a[7:0] ^ h ^ key;
  endfunction

  // Source RAM returns data the cycle after a read; noise otherwise.
  always @(negedge clk) begin
    cyc++;
    if (rd_q) SRC_DATA = mem(rd_a);
    else      SRC_DATA = 8'($urandom);
    rd_q = !SRC_RD_n;
    rd_a = SRC_ADDR;
    if (SRC_RD_n === 1'b0) begin
      rd_log.push_back(SRC_ADDR);
      if (first_rd < 0) first_rd = cyc;
      if (!V_BLANK) rd_novb++;
      if (prev_rd) rd_dbl++;
    end
    if (OBJ_WE_n === 1'b0) begin
      wr_log.push_back({OBJ_ADDR, OBJ_DATA});
      if (prev_we) we_dbl++;
    end
    if (DONE === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
      if (prev_done) done_dbl++;
    end
    prev_rd   = (SRC_RD_n === 1'b0);
    prev_we   = (OBJ_WE_n === 1'b0);
    prev_done = (DONE === 1'b1);
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  task automatic clear_logs();
    rd_log.delete();
    wr_log.delete();
    first_rd = -1;
    done_cyc = -1;
    done_cnt = 0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (DONE !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    check(tag, 32'(DONE === 1'b1), 32'd1);
  endtask

  task automatic wait_wr(input string tag, input int idx);
    int n = 0;
    while (!(OBJ_WE_n === 1'b0 && OBJ_ADDR[6:0] == 7'(idx))
           && n < 2000) begin
      tick();
      n++;
    end
    check(tag, 32'(OBJ_WE_n === 1'b0), 32'd1);
  endtask

  // Expected copy: byte i read from {base,0,i}, written to {obex,i}.
  task automatic check_xfer(input string tag,
                            input logic [7:0] base,
                            input logic obex,
                            input int off);
    int bad = 0;
    logic [15:0] sa;
    logic [15:0] want;
    for (int i = 0; i < 128; i++) begin
      sa   = {base, 1'b0, 7'(i)};
      want = {obex, 7'(i), mem(sa)};
      if (off + i >= wr_log.size()) bad++;
      else if (wr_log[off + i] !== want) bad++;
      if (off + i >= rd_log.size()) bad++;
      else if (rd_log[off + i] !== sa) bad++;
    end
    check(tag, 32'(bad), 32'd0);
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] b2;
    logic       o;
    logic       o2;
    int         gap;
    int         n;

    key = 8'($urandom);
    repeat (3) tick();
    check("rst_bus_req", 32'(BUS_REQ), 32'd0);
    check("rst_rd_n", 32'(SRC_RD_n), 32'd1);
    check("rst_we_n", 32'(OBJ_WE_n), 32'd1);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_done", 32'(DONE), 32'd0);
    check("rst_src_addr", 32'(SRC_ADDR), 32'd0);
    check("rst_obj_addr", 32'(OBJ_ADDR), 32'd0);
    check("rst_obj_data", 32'(OBJ_DATA), 32'd0);

    nRESET = 1'b1;
    V_BLANK = 1'b1;
    BUS_GNT = 1'b1;
    tick();

    // Uninterrupted copy
    SRC_BASE = 8'h88;
    OBJEX = 1'b1;
    clear_logs();
    pulse_start();
    wait_done("t1_done_seen");
    tick();
    tick();
    check("t1_latency", 32'(done_cyc - first_rd), 32'd384);
    check("t1_nwr", 32'(wr_log.size()), 32'd128);
    check_xfer("t1_data", 8'h88, 1'b1, 0);
    check("t1_ndone", 32'(done_cnt), 32'd1);
    check("t1_idle", 32'(BUSY), 32'd0);

    // Vblank ends after byte 40
    b = 8'($urandom);
    o = 1'($urandom);
    SRC_BASE = b;
    OBJEX = o;
    clear_logs();
    pulse_start();
    wait_wr("t2_wr40", 40);
    V_BLANK = 1'b0;
    gap = $urandom_range(4, 20);
    repeat (gap) tick();
    check("t2_pause_rds", 32'(rd_log.size()), 32'd41);
    check("t2_pause_req", 32'(BUS_REQ), 32'd0);
    check("t2_pause_busy", 32'(BUSY), 32'd1);
    V_BLANK = 1'b1;
    wait_done("t2_done_seen");
    tick();
    tick();
    if (rd_log.size() > 41)
      check("t2_resume", 32'(rd_log[41]), 32'({b, 8'h29}));
    else
      check("t2_resume_cnt", 32'(rd_log.size()), 32'd42);
    check("t2_nwr", 32'(wr_log.size()), 32'd128);
    check_xfer("t2_data", b, o, 0);
    check("t2_rd_novb", 32'(rd_novb), 32'd0);

    // Grant lost during LAT of byte 5
    b = 8'($urandom);
    o = 1'($urandom);
    SRC_BASE = b;
    OBJEX = o;
    clear_logs();
    pulse_start();
    n = 0;
    while (!(SRC_RD_n === 1'b0 && SRC_ADDR[6:0] == 7'd5) && n < 2000) begin
      tick();
      n++;
    end
    check("t3_rd5", 32'(SRC_RD_n === 1'b0), 32'd1);
    tick();
    BUS_GNT = 1'b0;
    tick();
    check("t3_wr5", 32'({OBJ_WE_n, OBJ_ADDR}), 32'({1'b0, o, 7'd5}));
    gap = $urandom_range(3, 10);
    repeat (gap) tick();
    check("t3_req_held", 32'(BUS_REQ), 32'd1);
    check("t3_no_rd", 32'(rd_log.size()), 32'd6);
    BUS_GNT = 1'b1;
    wait_done("t3_done_seen");
    tick();
    tick();
    check("t3_nwr", 32'(wr_log.size()), 32'd128);
    check_xfer("t3_data", b, o, 0);

    // Two STARTs mid-transfer collapse into one follow-up copy
    b = 8'($urandom);
    o = 1'($urandom);
    o2 = 1'($urandom);
    b2 = 8'h90;
    SRC_BASE = b;
    OBJEX = o;
    clear_logs();
    pulse_start();
    wait_wr("t4_wr10", 10);
    SRC_BASE = b2;
    OBJEX = o2;
    pulse_start();
    tick();
    pulse_start();
    wait_done("t4_done1_seen");
    tick();
    check("t4_restart", 32'(BUSY), 32'd1);
    wait_done("t4_done2_seen");
    repeat (20) tick();
    check("t4_ndone", 32'(done_cnt), 32'd2);
    check("t4_idle", 32'(BUSY), 32'd0);
    check("t4_nwr", 32'(wr_log.size()), 32'd256);
    check_xfer("t4_first", b, o, 0);
    check_xfer("t4_second", b2, o2, 128);

    // Reset during WR of byte 64
    b = 8'($urandom);
    o = 1'($urandom);
    SRC_BASE = b;
    OBJEX = o;
    clear_logs();
    pulse_start();
    wait_wr("t5_wr64", 64);
    nRESET = 1'b0;
    #1;
    check("t5_we_n", 32'(OBJ_WE_n), 32'd1);
    check("t5_busy", 32'(BUSY), 32'd0);
    check("t5_bus_req", 32'(BUS_REQ), 32'd0);
    check("t5_src_addr", 32'(SRC_ADDR), 32'd0);
    check("t5_obj_data", 32'(OBJ_DATA), 32'd0);
    repeat (2) tick();
    check("t5_nwr", 32'(wr_log.size()), 32'd64);
    b = 8'($urandom);
    o = 1'($urandom);
    SRC_BASE = b;
    OBJEX = o;
    clear_logs();
    nRESET = 1'b1;
    START = 1'b1;
    tick();
    START = 1'b0;
    check("t5_first_start", 32'(BUSY), 32'd1);
    wait_done("t5_done_seen");
    tick();
    tick();
    check("t5_nwr2", 32'(wr_log.size()), 32'd128);
    check_xfer("t5_data", b, o, 0);

    check("rd_pulse_1cyc", 32'(rd_dbl), 32'd0);
    check("we_pulse_1cyc", 32'(we_dbl), 32'd0);
    check("done_pulse_1cyc", 32'(done_dbl), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
